// File: rtl/laplace_pkg.sv
// Shared constants and state encoding for the cross-window generator.
package laplace_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        FLUSH
    } state_t;

endpackage

// File: rtl/laplace_window_gen_line_buffer.sv
// Fixed-depth pixel delay built as a circular buffer.
// o_data is the pixel written DEPTH enabled cycles earlier.
module line_buffer
    import laplace_pkg::*;
#(
    parameter int DEPTH  = IMG_W_DEF,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_ptr;

    assign o_data = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/laplace_window_gen.sv
// Raster-stream to 5-point cross window generator with zero padding
// and self-flush of the last image row.
module laplace_window_gen #(
    parameter int IMG_W = laplace_pkg::IMG_W_DEF,
    parameter int IMG_H = laplace_pkg::IMG_H_DEF,
    parameter int PIX_W = laplace_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
    output logic             win_last
);

    import laplace_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);

    state_t           r_state;
    logic [CW-1:0]    r_in_cnt;
    logic [XW-1:0]    r_cx;
    logic [YW-1:0]    r_cy;
    logic [PIX_W-1:0] r_tap0;
    logic [PIX_W-1:0] r_tap1;
    logic [PIX_W-1:0] r_tap2;

    logic [PIX_W-1:0] w_lb0_q;
    logic [PIX_W-1:0] w_lb1_q;
    logic [PIX_W-1:0] w_din;
    logic             w_fire;
    logic             w_acc;
    logic             w_flush_step;
    logic             w_load;
    logic             w_shift;
    logic             w_xlast;
    logic             w_ylast;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (r_state)
                FILL:    in_ready = 1'b1;
                STREAM:  in_ready = !win_valid || win_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign w_fire       = win_valid && win_ready;
    assign w_acc        = in_valid && in_ready;
    assign w_flush_step = (r_state == FLUSH)
                        && !(win_valid && win_last)
                        && (!win_valid || win_ready);
    assign w_load       = ((r_state == STREAM) && w_acc) || w_flush_step;
    assign w_shift      = w_acc || w_flush_step;
    assign w_din        = (r_state == FLUSH) ? '0 : in_pixel;
    assign w_xlast      = (r_cx == XW'(IMG_W - 1));
    assign w_ylast      = (r_cy == YW'(IMG_H - 1));

    // Taps hold n-W+1, n-W, n-W-1; the buffers cover the rest of 2*W.
    line_buffer #(
        .DEPTH  (IMG_W - 2),
        .DATA_W (PIX_W)
    ) u_lb0 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift),
        .i_data (w_din),
        .o_data (w_lb0_q)
    );

    line_buffer #(
        .DEPTH  (IMG_W - 1),
        .DATA_W (PIX_W)
    ) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift),
        .i_data (r_tap2),
        .o_data (w_lb1_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FILL;
            r_in_cnt  <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_tap0    <= '0;
            r_tap1    <= '0;
            r_tap2    <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            b         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            h         <= '0;
        end else begin
            if (w_shift) begin
                r_tap0 <= w_lb0_q;
                r_tap1 <= r_tap0;
                r_tap2 <= r_tap1;
            end

            if (w_load) begin
                win_valid <= 1'b1;
                win_last  <= w_xlast && w_ylast;
                b         <= (r_cy == '0) ? '0 : w_lb1_q;
                d         <= (r_cx == '0) ? '0 : r_tap2;
                e         <= r_tap1;
                f         <= w_xlast ? '0 : r_tap0;
                h         <= w_ylast ? '0 : w_din;
                if (w_xlast) begin
                    r_cx <= '0;
                    r_cy <= w_ylast ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end else if (w_fire) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end

            unique case (r_state)
                FILL: begin
                    if (w_acc) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == CW'(IMG_W - 1)) begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (w_acc) begin
                        if (r_in_cnt == CW'(NPIX - 1)) begin
                            r_in_cnt <= '0;
                            r_state  <= FLUSH;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_fire && win_last) begin
                        r_state <= FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laplace_window_gen.sv
// Randomized scoreboard bench for laplace_window_gen on a 4x3 image.
module tb_laplace_window_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct {
        int b;
        int d;
        int e;
        int f;
        int h;
        int last;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       win_valid;
    logic       win_ready;
    logic [7:0] b, d, e, f, h;
    logic       win_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    win_t sb[$];
    win_t mw;
    int   rdy_mode   = 0;
    int   frame_wins = 0;
    int   win_idx    = 0;

    always #5 clk = ~clk;

    laplace_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .b         (b),
        .d         (d),
        .e         (e),
        .f         (f),
        .h         (h),
        .win_last  (win_last)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pixel value at (x,y) with zero padding outside the image.
    function automatic int px_at(input int pix[N], input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
        return pix[y*W + x];
    endfunction

    task automatic push_frame(input int pix[N]);
        win_t w;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                w.b    = px_at(pix, x, y-1);
                w.d    = px_at(pix, x-1, y);
                w.e    = px_at(pix, x, y);
                w.f    = px_at(pix, x+1, y);
                w.h    = px_at(pix, x, y+1);
                w.last = (x == W-1 && y == H-1) ? 1 : 0;
                sb.push_back(w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            frame_wins = 0;
        end else if (win_valid && win_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mw = sb.pop_front();
                check($sformatf("win%0d_b", win_idx), b, mw.b);
                check($sformatf("win%0d_d", win_idx), d, mw.d);
                check($sformatf("win%0d_e", win_idx), e, mw.e);
                check($sformatf("win%0d_f", win_idx), f, mw.f);
                check($sformatf("win%0d_h", win_idx), h, mw.h);
                check($sformatf("win%0d_last", win_idx), win_last, mw.last);
            end
            win_idx++;
            frame_wins++;
            if (win_last) begin
                check("frame_win_count", frame_wins, N);
                frame_wins = 0;
            end
        end
    end

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = 1'b0;
                default: win_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_pixel(input logic [7:0] px, input int gap);
        int t  = 0;
        bit ok = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = px;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int frm[N];
        int fa[N];
        int fb[N];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_last", win_last, 0);
        check("rst_data", b | d | e | f | h, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("fill_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Ramp frame 1..12, consumer always ready
        for (int i = 0; i < N; i++) frm[i] = i + 1;
        push_frame(frm);
        for (int i = 0; i < N; i++) begin
            drive_pixel(8'(frm[i]), 0);
            if (i == W-1 || i == W || i == N-1) begin
                @(negedge clk);
                if (i == W-1) check("no_win_in_fill", win_valid, 0);
                if (i == W) begin
                    check("first_win_valid", win_valid, 1);
                    check("first_win_e", e, 1);
                    check("first_win_h", h, 5);
                end
                if (i == N-1) check("flush_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
            end
        end
        wait_idle(100);
        @(negedge clk);
        check("refill_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Consumer stall for 5 cycles mid-row
        for (int i = 0; i < N; i++) frm[i] = $urandom_range(0, 255);
        push_frame(frm);
        for (int i = 0; i < 6; i++) drive_pixel(8'(frm[i]), 0);
        rdy_mode = 1;
        in_valid = 1'b1;
        in_pixel = 8'(frm[6]);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_win_valid", win_valid, 1);
            check("stall_hold_b", b, sb[0].b);
            check("stall_hold_e", e, sb[0].e);
            check("stall_hold_h", h, sb[0].h);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        for (int i = 6; i < N; i++) drive_pixel(8'(frm[i]), 0);
        wait_idle(100);

        // Reset after 6 pixels, then a fresh ramp frame
        for (int i = 0; i < N; i++) frm[i] = $urandom_range(0, 255);
        push_frame(frm);
        for (int i = 0; i < 6; i++) drive_pixel(8'(frm[i]), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_win_valid", win_valid, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) frm[i] = i + 1;
        push_frame(frm);
        for (int i = 0; i < N; i++) begin
            drive_pixel(8'(frm[i]), 0);
            if (i == W) begin
                @(negedge clk);
                check("restart_b", b, 0);
                check("restart_d", d, 0);
                check("restart_e", e, 1);
                check("restart_f", f, 2);
                check("restart_h", h, 5);
                @(posedge clk);
                #1;
            end
        end
        wait_idle(100);

        // Two random frames back-to-back with random gaps and backpressure
        for (int i = 0; i < N; i++) begin
            fa[i] = $urandom_range(0, 255);
            fb[i] = $urandom_range(0, 255);
        end
        push_frame(fa);
        push_frame(fb);
        rdy_mode = 2;
        for (int i = 0; i < N; i++) drive_pixel(8'(fa[i]), $urandom_range(0, 2));
        for (int i = 0; i < N; i++) drive_pixel(8'(fb[i]), $urandom_range(0, 2));
        wait_idle(400);
        rdy_mode = 0;
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
